// File: rtl/wfq_req_gen.sv
// wfq_req_gen: request-side transmitter for the WFQ rank engine.
// Takes (class_id, pkt_len) descriptors, looks up the class weight in a
// CPU-writable table, divides pkt_len by the weight with a bit-serial
// restoring divider, and emits a one-cycle req_valid pulse with the result.
// Optional build macro: WFQ_REQ_GEN_FAST_POW2_EN. When defined, power-of-two
// weights bypass the divider and use a shift/mask in the LOAD cycle.
// Reset rstn is synchronous and active-low.

module wfq_req_gen #(
  parameter int CLASS_WIDTH  = 5,
  parameter int WEIGHT_WIDTH = 16,
  parameter int PKT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [CLASS_WIDTH-1:0]  in_class_id,
  input  logic [PKT_WIDTH-1:0]    in_pkt_len,
  input  logic                    cfg_wr_en,
  input  logic [CLASS_WIDTH-1:0]  cfg_class_id,
  input  logic [WEIGHT_WIDTH-1:0] cfg_weight,
  output logic                    req_valid,
  output logic [CLASS_WIDTH-1:0]  req_class_id,
  output logic [WEIGHT_WIDTH-1:0] req_div_quotient,
  output logic [WEIGHT_WIDTH-1:0] req_div_remain,
  output logic                    busy
);

  localparam int DEPTH = 1 << CLASS_WIDTH;
  localparam int CNT_W = (PKT_WIDTH > 1) ? $clog2(PKT_WIDTH) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_OUT  = 2'd3;

  logic [1:0]              state;
  logic [WEIGHT_WIDTH-1:0] weight_tbl [DEPTH];
  logic [WEIGHT_WIDTH-1:0] weight_rd;

  // Descriptor captured at accept time.
  logic [CLASS_WIDTH-1:0]  cls_q;
  logic [PKT_WIDTH-1:0]    pkt_q;

  // Divider datapath registers.
  logic [WEIGHT_WIDTH-1:0] divisor;
  logic [WEIGHT_WIDTH-1:0] rem;
  logic [PKT_WIDTH-1:0]    dividend;
  logic [PKT_WIDTH-1:0]    quot;
  logic [CNT_W-1:0]        cnt;

  // Next values for one restoring-division step.
  logic [WEIGHT_WIDTH:0]   rem_shift;
  logic                    div_ge;
  logic [WEIGHT_WIDTH-1:0] rem_step;
  logic [PKT_WIDTH-1:0]    quot_step;

  assign in_ready  = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign weight_rd = weight_tbl[cls_q];

  // Weight table: CPU writes land on the next edge, so a LOAD in the same
  // cycle as a write to its class still reads the previous weight.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      // NOTE: every entry is reset explicitly because all classes must start
      // at weight 1; a table with a reset value has to be built from flops.
      for (int i = 0; i < DEPTH; i++) begin
        weight_tbl[i] <= WEIGHT_WIDTH'(1);
      end
    end else if (cfg_wr_en) begin
      weight_tbl[cfg_class_id] <= cfg_weight;
    end
  end

  // One restoring-division step: shift in the next dividend bit, subtract
  // the divisor when it fits and record the quotient bit.
  always_comb begin
    // NOTE: blocking assignments here because later lines read the values
    // computed above them within the same evaluation; every output gets a
    // value on every path, so no latch is inferred.
    rem_shift = {rem, dividend[PKT_WIDTH-1]};
    div_ge    = (rem_shift >= {1'b0, divisor});
    rem_step  = div_ge ? WEIGHT_WIDTH'(rem_shift - {1'b0, divisor})
                       : WEIGHT_WIDTH'(rem_shift);
    quot_step = (quot << 1) | PKT_WIDTH'(div_ge);
  end

`ifdef WFQ_REQ_GEN_FAST_POW2_EN
  logic                    is_pow2;
  logic [WEIGHT_WIDTH-1:0] pow2_quot;
  logic [WEIGHT_WIDTH-1:0] pow2_rem;

  // Power-of-two weight detection: quotient is a right shift by the bit
  // position, remainder is the bits below it.
  always_comb begin
    is_pow2   = 1'b0;
    pow2_quot = '0;
    pow2_rem  = WEIGHT_WIDTH'(pkt_q) & (weight_rd - WEIGHT_WIDTH'(1));
    for (int k = 0; k < WEIGHT_WIDTH; k++) begin
      if (weight_rd == (WEIGHT_WIDTH'(1) << k)) begin
        is_pow2   = 1'b1;
        pow2_quot = WEIGHT_WIDTH'(pkt_q) >> k;
      end
    end
  end
`endif

  // Control FSM and datapath: accept, load divisor, iterate, publish result.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state            <= ST_IDLE;
      cls_q            <= '0;
      pkt_q            <= '0;
      divisor          <= '0;
      rem              <= '0;
      dividend         <= '0;
      quot             <= '0;
      cnt              <= '0;
      req_valid        <= 1'b0;
      req_class_id     <= '0;
      req_div_quotient <= '0;
      req_div_remain   <= '0;
    end else begin
      // req_valid is a pulse; it is only raised on the edge entering OUT.
      req_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            cls_q <= in_class_id;
            pkt_q <= in_pkt_len;
            state <= ST_LOAD;
          end
        end

        ST_LOAD: begin
          divisor  <= weight_rd;
          rem      <= '0;
          dividend <= pkt_q;
          quot     <= '0;
          cnt      <= CNT_W'(PKT_WIDTH - 1);
          if (weight_rd == '0) begin
            // Zero weight saturates the quotient instead of dividing.
            req_valid        <= 1'b1;
            req_class_id     <= cls_q;
            req_div_quotient <= '1;
            req_div_remain   <= '0;
            state            <= ST_OUT;
          end
`ifdef WFQ_REQ_GEN_FAST_POW2_EN
          else if (is_pow2) begin
            req_valid        <= 1'b1;
            req_class_id     <= cls_q;
            req_div_quotient <= pow2_quot;
            req_div_remain   <= pow2_rem;
            state            <= ST_OUT;
          end
`endif
          else begin
            state <= ST_DIV;
          end
        end

        ST_DIV: begin
          rem      <= rem_step;
          quot     <= quot_step;
          dividend <= dividend << 1;
          cnt      <= cnt - CNT_W'(1);
          if (cnt == '0) begin
            req_valid        <= 1'b1;
            req_class_id     <= cls_q;
            req_div_quotient <= WEIGHT_WIDTH'(quot_step);
            req_div_remain   <= rem_step;
            state            <= ST_OUT;
          end
        end

        ST_OUT: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wfq_req_gen.sv
// Self-checking bench for wfq_req_gen: reset values, a table of directed
// descriptors, hand-written multi-cycle sequences (config write during LOAD
// and DIV, held in_valid, reset mid-division) and randomized descriptors
// checked against an arithmetic reference model.

module tb_wfq_req_gen;

  localparam int CW = 5;
  localparam int WW = 16;
  localparam int PW = 16;
  localparam int SLOW_LAT = PW + 2;
`ifdef WFQ_REQ_GEN_FAST_POW2_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic          clk;
  logic          rstn;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_class_id;
  logic [PW-1:0] in_pkt_len;
  logic          cfg_wr_en;
  logic [CW-1:0] cfg_class_id;
  logic [WW-1:0] cfg_weight;
  logic          req_valid;
  logic [CW-1:0] req_class_id;
  logic [WW-1:0] req_div_quotient;
  logic [WW-1:0] req_div_remain;
  logic          busy;

  int errors = 0;
  int checks = 0;

  // Bench's own view of the weight table.
  logic [WW-1:0] shadow [1 << CW];

  typedef struct {
    logic [CW-1:0] cls;
    logic [PW-1:0] len;
    bit            set_w;
    logic [WW-1:0] w;
    logic [WW-1:0] q;
    logic [WW-1:0] r;
    int            lat_slow;
    int            lat_fast;
  } vec_t;

  vec_t vecs [11];

  // Hold-in_valid sequence bookkeeping.
  int            np, tot, b_acc, lat1;
  bit            drop;
  int            pc   [2];
  logic [CW-1:0] pcls [2];
  logic [WW-1:0] pq   [2];
  logic [WW-1:0] pr   [2];
  int            pulses;

  // Random-test scratch.
  logic [CW-1:0] r_cls;
  logic [PW-1:0] r_len;
  logic [WW-1:0] r_w, r_q, r_r;
  int            sel;

  wfq_req_gen #(
    .CLASS_WIDTH (CW),
    .WEIGHT_WIDTH(WW),
    .PKT_WIDTH   (PW)
  ) dut (
    .clk             (clk),
    .rstn            (rstn),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_class_id     (in_class_id),
    .in_pkt_len      (in_pkt_len),
    .cfg_wr_en       (cfg_wr_en),
    .cfg_class_id    (cfg_class_id),
    .cfg_weight      (cfg_weight),
    .req_valid       (req_valid),
    .req_class_id    (req_class_id),
    .req_div_quotient(req_div_quotient),
    .req_div_remain  (req_div_remain),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference model: latency from the weight alone.
  function automatic int model_lat(input logic [WW-1:0] w);
    if (w == '0) return 2;
    if (FAST && ($countones(w) == 1)) return 2;
    return SLOW_LAT;
  endfunction

  // Reference model: plain integer division with the zero-weight rule.
  function automatic void model_div(input logic [WW-1:0] len, input logic [WW-1:0] w,
                                    output logic [WW-1:0] q, output logic [WW-1:0] r);
    if (w == '0) begin
      q = '1;
      r = '0;
    end else begin
      q = len / w;
      r = len % w;
    end
  endfunction

  task automatic cfg_write(input logic [CW-1:0] cls, input logic [WW-1:0] w);
    cfg_wr_en    = 1'b1;
    cfg_class_id = cls;
    cfg_weight   = w;
    @(negedge clk);
    cfg_wr_en    = 1'b0;
    shadow[cls]  = w;
  endtask

  // Send one descriptor and check the resulting pulse. Optionally writes a new
  // weight for the same class during the given cycle (0 = no write).
  task automatic run_desc(input logic [CW-1:0] cls, input logic [PW-1:0] len,
                          input logic [WW-1:0] eq, input logic [WW-1:0] er,
                          input int elat, input int wr_cyc, input logic [WW-1:0] wr_w,
                          input string nm);
    int n, lat, low_cnt, busy_cnt;
    bit seen;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({nm, "/idle"}, 32'(in_ready), 32'd1);
    in_valid    = 1'b1;
    in_class_id = cls;
    in_pkt_len  = len;
    @(negedge clk);
    in_valid = 1'b0;
    seen = 1'b0;
    low_cnt = 0;
    busy_cnt = 0;
    for (lat = 1; lat <= 40; lat++) begin
      if (!in_ready) low_cnt++;
      if (busy) busy_cnt++;
      if (req_valid) begin
        seen = 1'b1;
        break;
      end
      cfg_wr_en    = (lat == wr_cyc);
      cfg_class_id = cls;
      cfg_weight   = wr_w;
      @(negedge clk);
    end
    cfg_wr_en = 1'b0;
    if (wr_cyc > 0 && wr_cyc < lat) shadow[cls] = wr_w;
    check({nm, "/pulse"},  32'(seen), 32'd1);
    check({nm, "/lat"},    32'(lat), 32'(elat));
    check({nm, "/class"},  32'(req_class_id), 32'(cls));
    check({nm, "/quot"},   32'(req_div_quotient), 32'(eq));
    check({nm, "/rem"},    32'(req_div_remain), 32'(er));
    check({nm, "/notrdy"}, 32'(low_cnt), 32'(lat));
    check({nm, "/busy"},   32'(busy_cnt), 32'(lat));
    @(negedge clk);
    check({nm, "/one_cyc"}, 32'(req_valid), 32'd0);
    check({nm, "/rdy_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    rstn = 1'b0;
    in_valid = 1'b0;
    in_class_id = '0;
    in_pkt_len = '0;
    cfg_wr_en = 1'b0;
    cfg_class_id = '0;
    cfg_weight = '0;
    for (int i = 0; i < (1 << CW); i++) shadow[i] = WW'(1);

    //                cls     len        set  w          q          r      slow fast
    vecs[0]  = '{5'd3,  16'd1500,  1'b0, 16'd0,     16'd1500,  16'd0,     18, 2};
    vecs[1]  = '{5'd5,  16'd100,   1'b1, 16'd7,     16'd14,    16'd2,     18, 18};
    vecs[2]  = '{5'd9,  16'd200,   1'b1, 16'd0,     16'hFFFF,  16'd0,     2,  2};
    vecs[3]  = '{5'd10, 16'd1000,  1'b1, 16'd64,    16'd15,    16'd40,    18, 2};
    vecs[4]  = '{5'd11, 16'd1000,  1'b1, 16'd7,     16'd142,   16'd6,     18, 18};
    vecs[5]  = '{5'd12, 16'd0,     1'b1, 16'd3,     16'd0,     16'd0,     18, 18};
    vecs[6]  = '{5'd13, 16'hFFFF,  1'b1, 16'hFFFF,  16'd1,     16'd0,     18, 18};
    vecs[7]  = '{5'd14, 16'hFFFF,  1'b1, 16'h8000,  16'd1,     16'h7FFF,  18, 2};
    vecs[8]  = '{5'd15, 16'd999,   1'b1, 16'd1000,  16'd0,     16'd999,   18, 18};
    vecs[9]  = '{5'd31, 16'hFFFF,  1'b1, 16'd2,     16'h7FFF,  16'd1,     18, 2};
    vecs[10] = '{5'd0,  16'd12345, 1'b1, 16'd1,     16'd12345, 16'd0,     18, 2};

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst/in_ready", 32'(in_ready), 32'd1);
    check("rst/busy", 32'(busy), 32'd0);
    check("rst/req_valid", 32'(req_valid), 32'd0);
    check("rst/req_class", 32'(req_class_id), 32'd0);
    check("rst/req_quot", 32'(req_div_quotient), 32'd0);
    check("rst/req_rem", 32'(req_div_remain), 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    // Directed vector table.
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].set_w) cfg_write(vecs[i].cls, vecs[i].w);
      run_desc(vecs[i].cls, vecs[i].len, vecs[i].q, vecs[i].r,
               FAST ? vecs[i].lat_fast : vecs[i].lat_slow, 0, '0,
               $sformatf("vec%0d", i));
    end

    // Write to the same class in the LOAD cycle: old weight 5 is used.
    cfg_write(5'd20, 16'd5);
    run_desc(5'd20, 16'd103, 16'd20, 16'd3, SLOW_LAT, 1, 16'd0, "wr_load");
    run_desc(5'd20, 16'd50, 16'hFFFF, 16'd0, 2, 0, '0, "wr_load_after");

    // Write during DIV does not disturb the in-flight division.
    cfg_write(5'd21, 16'd9);
    run_desc(5'd21, 16'd1000, 16'd111, 16'd1, SLOW_LAT, 6, 16'd10, "wr_div");
    run_desc(5'd21, 16'd1000, 16'd100, 16'd0, SLOW_LAT, 0, '0, "wr_div_after");

    // in_valid held continuously across two descriptors.
    cfg_write(5'd1, 16'd1);
    cfg_write(5'd2, 16'd1);
    in_valid    = 1'b1;
    in_class_id = 5'd1;
    in_pkt_len  = 16'd64;
    @(negedge clk);
    in_class_id = 5'd2;
    in_pkt_len  = 16'd128;
    np = 0; tot = 0; b_acc = -1; drop = 1'b0;
    pc[0] = 0; pc[1] = 0;
    pcls[0] = '0; pcls[1] = '0; pq[0] = '0; pq[1] = '0; pr[0] = '1; pr[1] = '1;
    for (int c = 1; c <= 60; c++) begin
      if (req_valid) begin
        if (np < 2) begin
          pc[np] = c; pcls[np] = req_class_id;
          pq[np] = req_div_quotient; pr[np] = req_div_remain;
          np++;
        end
        tot++;
      end
      if (in_valid && in_ready && b_acc < 0) begin
        b_acc = c;
        drop = 1'b1;
      end
      @(negedge clk);
      if (drop) in_valid = 1'b0;
    end
    lat1 = model_lat(16'd1);
    check("hold/pulses", 32'(tot), 32'd2);
    check("hold/a_lat", 32'(pc[0]), 32'(lat1));
    check("hold/b_accept", 32'(b_acc), 32'(lat1 + 1));
    check("hold/spacing", 32'(pc[1] - pc[0]), 32'(lat1 + 1));
    check("hold/a_class", 32'(pcls[0]), 32'd1);
    check("hold/b_class", 32'(pcls[1]), 32'd2);
    check("hold/a_quot", 32'(pq[0]), 32'd64);
    check("hold/b_quot", 32'(pq[1]), 32'd128);
    check("hold/a_rem", 32'(pr[0]), 32'd0);
    check("hold/b_rem", 32'(pr[1]), 32'd0);

    // Reset in cycle 8 of a division: no pulse, table back to 1.
    cfg_write(5'd4, 16'd7);
    in_valid    = 1'b1;
    in_class_id = 5'd4;
    in_pkt_len  = 16'd10;
    @(negedge clk);
    in_valid = 1'b0;
    pulses = 0;
    for (int c = 1; c < 8; c++) begin
      if (req_valid) pulses++;
      @(negedge clk);
    end
    if (req_valid) pulses++;
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < (1 << CW); i++) shadow[i] = WW'(1);
    for (int c = 0; c < 30; c++) begin
      if (req_valid) pulses++;
      @(negedge clk);
    end
    check("rst_mid/no_pulse", 32'(pulses), 32'd0);
    check("rst_mid/in_ready", 32'(in_ready), 32'd1);
    check("rst_mid/busy", 32'(busy), 32'd0);
    check("rst_mid/req_quot", 32'(req_div_quotient), 32'd0);
    run_desc(5'd4, 16'd10, 16'd10, 16'd0, model_lat(16'd1), 0, '0, "rst_mid/reread");

    // Randomized descriptors against the arithmetic model.
    for (int it = 0; it < 40; it++) begin
      r_cls = CW'($urandom_range(0, (1 << CW) - 1));
      sel = $urandom_range(0, 5);
      case (sel)
        0: r_w = '0;
        1: r_w = WW'(1) << $urandom_range(0, WW - 1);
        2: r_w = WW'($urandom_range(1, 20));
        3: r_w = WW'($urandom);
        5: r_w = WW'($urandom_range(1, 65535));
        default: r_w = shadow[r_cls];
      endcase
      if (sel != 4) cfg_write(r_cls, r_w);
      r_len = ($urandom_range(0, 3) == 0) ? PW'($urandom_range(0, 40)) : PW'($urandom);
      model_div(WW'(r_len), shadow[r_cls], r_q, r_r);
      run_desc(r_cls, r_len, r_q, r_r, model_lat(shadow[r_cls]), 0, '0,
               $sformatf("rnd%0d", it));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
